output_sender_ctrl: RTL

OUTPUT_SENDER_CTRL -- requirements
Module: output_sender_ctrl

---
 rtl/output_sender_ctrl_pkg.sv | 20 ++
 rtl/output_sender_ctrl_argmax_tracker.sv | 45 ++++
 rtl/output_sender_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/output_sender_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | output_sender_ctrl_pkg: state encodings shared by the sender FSM        |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
package output_sender_ctrl_pkg;

  localparam int NUMBER_OF_SENDER_STATES = 5;
  localparam int SENDER_STATE_WIDTH      = $clog2(NUMBER_OF_SENDER_STATES);

  typedef enum logic [SENDER_STATE_WIDTH-1:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } sender_state_t;

endpackage
`default_nettype wire

// File: rtl/output_sender_ctrl_argmax_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | argmax_tracker: running signed maximum and its index (ties keep lowest) |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module argmax_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  update,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [ADDR_WIDTH-1:0] index,
  output logic                  take,
  output logic [ADDR_WIDTH-1:0] max_index
);

  logic signed [DATA_WIDTH-1:0] r_max_value;
  logic [ADDR_WIDTH-1:0]        r_max_index;
  logic                         r_have;

  // Strict compare so an equal later value never displaces the earlier index.
  assign take      = !r_have || ($signed(value) > r_max_value);
  assign max_index = r_max_index;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_have      <= 1'b0;
      r_max_value <= '0;
      r_max_index <= '0;
    end else if (clear) begin
      r_have      <= 1'b0;
      r_max_value <= '0;
      r_max_index <= '0;
    end else if (update && take) begin
      r_have      <= 1'b1;
      r_max_value <= value;
      r_max_index <= index;
    end
  end

endmodule
`default_nettype wire

// File: rtl/output_sender_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | output_sender_ctrl: reads output memory and streams words downstream;  |
// | SENDER_ARGMAX_EN adds an argmax mode sending the winning index only.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module output_sender_ctrl
  import output_sender_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_sending,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  classification,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done_sending,
  output logic                  busy
);

  sender_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_counter;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  w_argmax_mode;
  logic [ADDR_WIDTH-1:0] w_win_index;

`ifdef SENDER_ARGMAX_EN
  logic                  r_argmax_mode;
  logic                  w_take;
  logic [ADDR_WIDTH-1:0] w_max_index;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_argmax_mode <= 1'b0;
    else if (r_state == S_IDLE && start_sending)
      r_argmax_mode <= classification;
  end

  argmax_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_argmax_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (r_state == S_IDLE && start_sending),
    .update   (r_state == S_LOAD && r_argmax_mode),
    .value    (mem_rd_data),
    .index    (r_counter),
    .take     (w_take),
    .max_index(w_max_index)
  );

  assign w_argmax_mode = r_argmax_mode;
  // The final word's comparison lands on the same edge as the send decision.
  assign w_win_index   = w_take ? r_counter : w_max_index;
`else
  logic w_unused_classification;
  assign w_unused_classification = classification;
  assign w_argmax_mode           = 1'b0;
  assign w_win_index             = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_counter    <= '0;
      r_last_addr  <= '0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr  <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      done_sending <= 1'b0;
      busy         <= 1'b0;
    end else begin
      mem_rd_en    <= 1'b0;
      done_sending <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_sending) begin
            r_state     <= S_READ;
            r_counter   <= '0;
            r_last_addr <= last_addr;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
            busy        <= 1'b1;
          end
        end
        S_READ: r_state <= S_LOAD;
        S_LOAD: begin
          if (w_argmax_mode && (r_counter != r_last_addr)) begin
            r_counter   <= r_counter + 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= r_counter + 1'b1;
            r_state     <= S_READ;
          end else begin
            out_data  <= w_argmax_mode ? DATA_WIDTH'(w_win_index) : mem_rd_data;
            out_valid <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            if (r_counter == r_last_addr) begin
              done_sending <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_counter   <= r_counter + 1'b1;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= r_counter + 1'b1;
              r_state     <= S_READ;
            end
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
